// File: rtl/led_pkg.sv
// Shared types and constants for the RGB LED PWM driver.
package led_pkg;

  // Blink gating state. IDLE and ON let the PWM through; OFF blanks all channels.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

  // Request-change counter width and its saturation ceiling.
  localparam int              CHG_CNT_W   = 8;
  localparam logic [CHG_CNT_W-1:0] CHG_CNT_MAX = 8'd255;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM colour channel: a duty shadow register that only reloads at a
// period boundary, the duty compare, and the registered pin driver.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                req,
  input  logic                phase,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

  logic [PWM_BITS-1:0] shadow_p0;
  logic                on_p0;

  // Capture the requested duty only at the end of a period so a period never
  // sees two different thresholds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_p0 <= '0;
    end else if (period_end) begin
      shadow_p0 <= duty;
    end
  end

  // All-ones duty is treated as fully on; otherwise the window is pwm_cnt < duty.
  always_comb begin
    on_p0 = req && phase && ((shadow_p0 == DUTY_FULL) || (pwm_cnt < shadow_p0));
  end

  // ---- stage boundary: compare result -> pin register ----
  // Register the pin so it is glitch-free at the board.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= on_p0;
    end
  end

endmodule

// File: rtl/led_rgb_pwm_driver.sv
// RGB LED pin driver: samples the colour requests, generates a shared PWM
// timebase, gates the channels with an optional blink, and flags/counts
// changes of the colour request.
module led_rgb_pwm_driver
  import led_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int PWM_BITS      = 4,
  parameter int BLINK_PERIODS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r,
  input  logic                 g,
  input  logic                 be,
  input  logic [PWM_BITS-1:0]  duty_r,
  input  logic [PWM_BITS-1:0]  duty_g,
  input  logic [PWM_BITS-1:0]  duty_b,
  input  logic                 blink_en,
  output logic                 led_r,
  output logic                 led_g,
  output logic                 led_b,
  output logic                 chg,
  output logic [CHG_CNT_W-1:0] chg_cnt
);

  localparam int                PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam int                BCNT_W   = $clog2(BLINK_PERIODS + 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

  // Saturating increment for the change counter; holds at the ceiling.
  function automatic logic [CHG_CNT_W-1:0] sat_inc(input logic [CHG_CNT_W-1:0] v);
    if (v == CHG_CNT_MAX) begin
      return v;
    end
    return v + CHG_CNT_W'(1);
  endfunction

  logic [2:0]          req_p0;
  logic [2:0]          req_p1;
  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                period_end;
  blink_state_t        state_q;
  blink_state_t        state_d;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [BCNT_W-1:0]   bcnt_d;
  logic                phase;

  // ---- stage boundary: pins -> req_p0 -> req_p1 ----
  // Sample the requests every clock and keep the previous sample for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_p0 <= '0;
      req_p1 <= '0;
    end else begin
      req_p0 <= {r, g, be};
      req_p1 <= req_p0;
    end
  end

  // ---- stage boundary: req compare -> chg pulse -> chg_cnt ----
  // One-cycle pulse for each sample that differs from the one before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg <= 1'b0;
    end else begin
      chg <= (req_p0 != req_p1);
    end
  end

  // Count change pulses, stopping at the ceiling instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt <= '0;
    end else if (chg) begin
      chg_cnt <= sat_inc(chg_cnt);
    end
  end

  assign tick       = (pre_cnt == PRE_LAST);
  assign period_end = tick && (pwm_cnt == PWM_LAST);

  // Prescaler: CLK_DIV clocks per PWM tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // PWM position within the period; wraps naturally at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Blink state and period counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Blink next-state: alternate ON/OFF every BLINK_PERIODS period ends while
  // enabled; dropping the enable returns to IDLE (always lit) immediately.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    phase   = 1'b1;
    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (blink_en) begin
          state_d = ON;
        end
      end
      ON: begin
        if (!blink_en) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else if (period_end) begin
          if (bcnt_q == BCNT_LAST) begin
            state_d = OFF;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      OFF: begin
        phase = 1'b0;
        if (!blink_en) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else if (period_end) begin
          if (bcnt_q == BCNT_LAST) begin
            state_d = ON;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .clk        (clk),
    .rst        (rst),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end),
    .duty       (duty_r),
    .req        (req_p0[2]),
    .phase      (phase),
    .led        (led_r)
  );

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .clk        (clk),
    .rst        (rst),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end),
    .duty       (duty_g),
    .req        (req_p0[1]),
    .phase      (phase),
    .led        (led_g)
  );

  led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .clk        (clk),
    .rst        (rst),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end),
    .duty       (duty_b),
    .req        (req_p0[0]),
    .phase      (phase),
    .led        (led_b)
  );

endmodule

// File: tb/tb_led_rgb_pwm_driver.sv
// Self-checking bench for led_rgb_pwm_driver with default parameters.
module tb_led_rgb_pwm_driver;

  localparam int PERIOD_CLK = 64;  // CLK_DIV * 2^PWM_BITS

  logic       clk = 1'b0;
  logic       rst;
  logic       r, g, be;
  logic [3:0] duty_r, duty_g, duty_b;
  logic       blink_en;
  logic       led_r, led_g, led_b;
  logic       chg;
  logic [7:0] chg_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_q[$];
  int cyc;

  led_rgb_pwm_driver #(.CLK_DIV(4), .PWM_BITS(4), .BLINK_PERIODS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .r        (r),
    .g        (g),
    .be       (be),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .blink_en (blink_en),
    .led_r    (led_r),
    .led_g    (led_g),
    .led_b    (led_b),
    .chg      (chg),
    .chg_cnt  (chg_cnt)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the sample taken at the falling edge
  // after edge n shows the LED computed from counter state n-1.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance to the first sample of the next PWM period and count the high
  // samples of each pin over that period. Optionally change duty_r mid-period.
  task automatic measure_period(input int chg_at, input logic [3:0] new_duty,
                                output int hr, output int hg, output int hb);
    @(negedge clk);
    for (int k = 0; k < PERIOD_CLK && ((cyc - 1) % PERIOD_CLK) != 0; k++) @(negedge clk);
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < PERIOD_CLK; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg_at) duty_r = new_duty;
      hr += (led_r === 1'b1) ? 1 : 0;
      hg += (led_g === 1'b1) ? 1 : 0;
      hb += (led_b === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    int hr, hg, hb, e;
    r = 1; g = 1; be = 1;
    duty_r = 4'd15; duty_g = 4'd15; duty_b = 4'd15;
    blink_en = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (led_r !== 1'b0) $display("FAIL rst_led_r got %b want 0", led_r); else pass_cnt++;
    total_cnt++; if (led_g !== 1'b0) $display("FAIL rst_led_g got %b want 0", led_g); else pass_cnt++;
    total_cnt++; if (led_b !== 1'b0) $display("FAIL rst_led_b got %b want 0", led_b); else pass_cnt++;
    total_cnt++; if (chg !== 1'b0) $display("FAIL rst_chg got %b want 0", chg); else pass_cnt++;
    total_cnt++; if (chg_cnt !== 8'd0) $display("FAIL rst_chg_cnt got %0d want 0", chg_cnt); else pass_cnt++;
    rst = 1'b0;
    // First period runs with duty 0, then all channels are fully on.
    for (int c = 0; c < 3; c++) exp_q.push_back(0);
    for (int c = 0; c < 3; c++) exp_q.push_back(PERIOD_CLK);
    for (int p = 0; p < 2; p++) begin
      measure_period(-1, 4'd0, hr, hg, hb);
      e = exp_q.pop_front(); total_cnt++;
      if (hr !== e) $display("FAIL reset_p%0d_r got %0d want %0d", p, hr, e); else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (hg !== e) $display("FAIL reset_p%0d_g got %0d want %0d", p, hg, e); else pass_cnt++;
      e = exp_q.pop_front(); total_cnt++;
      if (hb !== e) $display("FAIL reset_p%0d_b got %0d want %0d", p, hb, e); else pass_cnt++;
    end
  endtask

  task automatic test_pwm_duty();
    int hr, hg, hb, e;
    r = 1; g = 0; be = 0;
    duty_r = 4'd8; duty_g = 4'd15; duty_b = 4'd0;
    blink_en = 0;
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(32);
    exp_q.push_back(32);
    for (int p = 0; p < 3; p++) begin
      measure_period(-1, 4'd0, hr, hg, hb);
      e = exp_q.pop_front(); total_cnt++;
      if (hr !== e) $display("FAIL pwm8_p%0d_r got %0d want %0d", p, hr, e); else pass_cnt++;
      total_cnt++;
      if (hg !== 0) $display("FAIL pwm_gated_g_p%0d got %0d want 0", p, hg); else pass_cnt++;
    end
    // Shadow for the next period has already loaded 8; duty 0 lands one later.
    duty_r = 4'd0;
    exp_q.push_back(32);
    exp_q.push_back(0);
    exp_q.push_back(0);
    for (int p = 3; p < 6; p++) begin
      measure_period(-1, 4'd0, hr, hg, hb);
      e = exp_q.pop_front(); total_cnt++;
      if (hr !== e) $display("FAIL pwm0_p%0d_r got %0d want %0d", p, hr, e); else pass_cnt++;
    end
  endtask

  task automatic test_duty_change();
    int hr, hg, hb, e;
    r = 1; g = 0; be = 0;
    duty_r = 4'd8; duty_g = 4'd0; duty_b = 4'd0;
    blink_en = 0;
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(32);
    exp_q.push_back(16);
    exp_q.push_back(16);
    for (int p = 0; p < 4; p++) begin
      measure_period((p == 1) ? 32 : -1, 4'd4, hr, hg, hb);
      e = exp_q.pop_front(); total_cnt++;
      if (hr !== e) $display("FAIL duty_change_p%0d_r got %0d want %0d", p, hr, e); else pass_cnt++;
    end
  endtask

  task automatic test_blink();
    int hr, hg, hb, e;
    r = 0; g = 1; be = 0;
    duty_r = 4'd0; duty_g = 4'd15; duty_b = 4'd0;
    blink_en = 0;
    do_reset();
    measure_period(-1, 4'd0, hr, hg, hb);
    total_cnt++;
    if (hg !== 0) $display("FAIL blink_p0_g got %0d want 0", hg); else pass_cnt++;
    blink_en = 1;
    for (int p = 1; p <= 8; p++)  exp_q.push_back(PERIOD_CLK);
    for (int p = 9; p <= 16; p++) exp_q.push_back(0);
    for (int p = 17; p <= 24; p++) exp_q.push_back(PERIOD_CLK);
    for (int p = 1; p <= 24; p++) begin
      measure_period(-1, 4'd0, hr, hg, hb);
      e = exp_q.pop_front(); total_cnt++;
      if (hg !== e) $display("FAIL blink_p%0d_g got %0d want %0d", p, hg, e); else pass_cnt++;
    end
    // Period 25 is an OFF half-phase; drop the enable partway through.
    @(negedge clk);
    for (int k = 0; k < PERIOD_CLK && ((cyc - 1) % PERIOD_CLK) != 0; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    total_cnt++;
    if (led_g !== 1'b0) $display("FAIL blink_off_g got %b want 0", led_g); else pass_cnt++;
    blink_en = 0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (led_g !== 1'b1) $display("FAIL blink_drop_g got %b want 1", led_g); else pass_cnt++;
  endtask

  task automatic test_chg();
    int pulses, run, max_run, e;
    logic [2:0] combo;
    r = 0; g = 0; be = 0;
    duty_r = 4'd0; duty_g = 4'd0; duty_b = 4'd0;
    blink_en = 0;
    do_reset();
    pulses = 0; run = 0; max_run = 0;
    exp_q.push_back(7);  // pulses
    exp_q.push_back(1);  // widest pulse
    exp_q.push_back(7);  // chg_cnt
    for (int c = 0; c < 8; c++) begin
      combo = 3'(c);
      {r, g, be} = combo;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (chg === 1'b1) begin
          run++;
          if (run == 1) pulses++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
    end
    repeat (4) @(negedge clk);
    e = exp_q.pop_front(); total_cnt++;
    if (pulses !== e) $display("FAIL chg_pulses got %0d want %0d", pulses, e); else pass_cnt++;
    e = exp_q.pop_front(); total_cnt++;
    if (max_run !== e) $display("FAIL chg_width got %0d want %0d", max_run, e); else pass_cnt++;
    e = exp_q.pop_front(); total_cnt++;
    if (int'(chg_cnt) !== e) $display("FAIL chg_cnt_sweep got %0d want %0d", chg_cnt, e); else pass_cnt++;
    // 300 more changes: 7 + 300 exceeds the ceiling, so the count must hold.
    exp_q.push_back((7 + 300 > 255) ? 255 : 7 + 300);
    for (int k = 0; k < 300; k++) begin
      r = ~r;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    e = exp_q.pop_front(); total_cnt++;
    if (int'(chg_cnt) !== e) $display("FAIL chg_cnt_sat got %0d want %0d", chg_cnt, e); else pass_cnt++;
    total_cnt++;
    if (chg !== 1'b0) $display("FAIL chg_idle got %b want 0", chg); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int hr, hg, hb, e;
    r = 0; g = 1; be = 0;
    duty_r = 4'd0; duty_g = 4'd15; duty_b = 4'd0;
    blink_en = 1;
    do_reset();
    measure_period(-1, 4'd0, hr, hg, hb);
    measure_period(-1, 4'd0, hr, hg, hb);
    @(negedge clk);
    total_cnt++;
    if (led_g !== 1'b1) $display("FAIL mid_pre_g got %b want 1", led_g); else pass_cnt++;
    total_cnt++;
    if (chg_cnt === 8'd0) $display("FAIL mid_pre_cnt got %0d want nonzero", chg_cnt); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (led_g !== 1'b0) $display("FAIL mid_rst_g got %b want 0", led_g); else pass_cnt++;
    total_cnt++;
    if (chg_cnt !== 8'd0) $display("FAIL mid_rst_cnt got %0d want 0", chg_cnt); else pass_cnt++;
    g = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (chg_cnt !== 8'd0) $display("FAIL mid_post_cnt got %0d want 0", chg_cnt); else pass_cnt++;
    g = 1;
    // Blink restarts from IDLE with a cleared counter: lit for periods 1..7, dark in 8.
    for (int p = 1; p <= 7; p++) exp_q.push_back(PERIOD_CLK);
    exp_q.push_back(0);
    for (int p = 1; p <= 8; p++) begin
      measure_period(-1, 4'd0, hr, hg, hb);
      e = exp_q.pop_front(); total_cnt++;
      if (hg !== e) $display("FAIL mid_restart_p%0d_g got %0d want %0d", p, hg, e); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    r = 0; g = 0; be = 0;
    duty_r = 0; duty_g = 0; duty_b = 0;
    blink_en = 0;
    test_reset();
    test_pwm_duty();
    test_duty_change();
    test_blink();
    test_chg();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
